// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, load/store) onto one shared memory port.
// Load/store has priority; a starvation counter guarantees fetch a grant eventually.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [63:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [63:0] ls_addr,
    input  logic [63:0] ls_wdata,
    input  logic [7:0]  ls_wmask,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [63:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            owner_ls;
    logic [CW-1:0]   starve_cnt;
    logic            starved;
    logic            pick_ls;
    logic            pick_if;

    always_comb begin
        starved   = (starve_cnt == CW'(STARVE_LIMIT));
        pick_ls   = 1'b0;
        pick_if   = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                // Fetch only overrides load/store once it has waited the full limit.
                if (ls_req && !(if_req && starved)) begin
                    pick_ls   = 1'b1;
                    state_nxt = REQ;
                end else if (if_req) begin
                    pick_if   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ:     if (mem_ready)  state_nxt = WAIT;
            WAIT:    if (mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_ls   <= 1'b0;
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            ls_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            ls_rvalid  <= 1'b0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            if_gnt    <= pick_if;
            ls_gnt    <= pick_ls;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;

            if (pick_ls || pick_if) begin
                owner_ls  <= pick_ls;
                mem_req   <= 1'b1;
                mem_we    <= pick_ls & ls_we;
                mem_addr  <= pick_ls ? ls_addr : if_addr;
                mem_wdata <= pick_ls ? ls_wdata : '0;
                mem_wmask <= pick_ls ? ls_wmask : '0;
            end

            if (state == REQ && mem_ready) mem_req <= 1'b0;

            if (state == WAIT && mem_rvalid) begin
                if (owner_ls) begin
                    ls_rvalid <= 1'b1;
                    ls_rdata  <= mem_we ? '0 : mem_rdata;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= mem_rdata;
                end
            end

            if (!if_req || pick_if)                    starve_cnt <= '0;
            else if (pick_ls && !starved)              starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive load/store grants while fetch waits.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch request; held until if_gnt.
REQ-005 if_addr  in  64  fetch address.
REQ-006 if_gnt  out  1  one-cycle pulse: fetch request captured.
REQ-007 if_rvalid  out  1  one-cycle pulse: fetch data valid.
REQ-008 if_rdata  out  64  fetch read data.
REQ-009 ls_req  in  1  load/store request; held until ls_gnt.
REQ-010 ls_we  in  1  1 = store, 0 = load.
REQ-011 ls_addr  in  64  load/store address.
REQ-012 ls_wdata  in  64  store data.
REQ-013 ls_wmask  in  8  store byte mask.
REQ-014 ls_gnt  out  1  one-cycle pulse: load/store request captured.
REQ-015 ls_rvalid  out  1  one-cycle pulse: load data valid or store complete.
REQ-016 ls_rdata  out  64  load data; 0 for stores.
REQ-017 mem_req  out  1  request to shared memory port.
REQ-018 mem_we, mem_addr, mem_wdata, mem_wmask  out  1/64/64/8  captured request fields.
REQ-019 mem_ready  in  1  memory accepts mem_req this cycle.
REQ-020 mem_rvalid  in  1  memory response valid.
REQ-021 mem_rdata  in  64  memory response data.

Function
REQ-022 FSM states: IDLE, REQ, WAIT; all outputs registered.
REQ-023 IDLE: any request at the clock edge -> REQ; winner's fields captured into mem_* registers, owner register set, winner's gnt high for the following cycle only.
REQ-024 Priority: ls_req beats if_req, except if_req wins when starve_cnt == STARVE_LIMIT.
REQ-025 starve_cnt: +1 on each ls grant made while if_req high; cleared on if grant or any cycle if_req low; saturates at STARVE_LIMIT.
REQ-026 REQ: mem_req = 1 with stable mem_* fields; mem_ready at the edge -> WAIT, mem_req deasserted the next cycle.
REQ-027 WAIT: mem_rvalid at the edge -> IDLE; owner's rvalid pulses the next cycle with rdata = mem_rdata (ls store: ls_rdata = 0).
REQ-028 Non-owner rvalid stays 0; rdata outputs hold the last value when not valid.
REQ-029 mem_rvalid outside WAIT and mem_ready outside REQ are ignored.
REQ-030 One outstanding transaction only; requests arriving in REQ/WAIT wait for IDLE; no grant in the cycle leaving WAIT.
REQ-031 Minimum turnaround: req seen at edge t -> gnt at t+1, mem_req at t+1, accepted at t+1 edge if mem_ready high -> rvalid earliest t+3 given rvalid at t+2 edge.
REQ-032 ls_req and if_req simultaneous with starve_cnt < STARVE_LIMIT: ls granted; if stays pending, not dropped.

Reset
REQ-033 rst low asynchronously forces state IDLE, starve_cnt 0, owner = fetch, all outputs 0 (gnt, rvalid, mem_req, mem_* fields, rdata).
REQ-034 Reset mid-transaction abandons it; a late mem_rvalid after reset release in IDLE is ignored; no rvalid issued.
REQ-035 First arbitration at the first rising edge with rst high.

Verification
REQ-036 Single fetch: if_req=1, addr 0x8000_0000, mem_ready=1, mem_rvalid next cycle with rdata 0x1234 -> if_gnt at t+1, mem_addr 0x8000_0000, if_rvalid at t+3 with if_rdata 0x1234.
REQ-037 Store: ls_req, ls_we=1, addr 0x100, wdata 0xAA, wmask 0x01 -> mem_we=1, mem_wmask 0x01, ls_rvalid pulse with ls_rdata 0, if_rvalid 0.
REQ-038 Simultaneous if_req/ls_req, STARVE_LIMIT=4 -> ls granted first; ls_req held high continuously: 4 ls grants, then the 5th grant goes to fetch, starve_cnt back to 0.
REQ-039 mem_ready low for 3 cycles in REQ -> mem_req and mem_* fields stable for 3 cycles, no gnt repeats.
REQ-040 rst low during WAIT -> all outputs 0 immediately; mem_rvalid after release -> no rvalid; a fresh request completes normally.
REQ-041 Spurious mem_rvalid in IDLE and mem_ready in WAIT -> no state change, no rvalid.
